// File: rtl/mem_req_bridge.sv
// Decoupling bridge: buffers CPU load/store requests in a FIFO toward Memory and returns
// load data through a one-entry response register, tracking outstanding loads.
module mem_req_bridge #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       cpu_req_addr,
  input  logic [DATA_W-1:0]       cpu_req_data,
  input  logic [2:0]              cpu_req_mask,
  input  logic                    cpu_req_wr,
  input  logic                    cpu_req_notify,
  output logic                    cpu_req_sync,
  output logic [ADDR_W-1:0]       mem_req_addr,
  output logic [DATA_W-1:0]       mem_req_data,
  output logic [2:0]              mem_req_mask,
  output logic                    mem_req_wr,
  output logic                    mem_req_notify,
  input  logic                    mem_req_sync,
  input  logic [DATA_W-1:0]       mem_rsp_data,
  input  logic                    mem_rsp_notify,
  output logic                    mem_rsp_sync,
  output logic [DATA_W-1:0]       cpu_rsp_data,
  output logic                    cpu_rsp_notify,
  input  logic                    cpu_rsp_sync,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    err_unexp_rsp
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [2:0]        mask;
    logic              wr;
  } req_t;

  req_t             fifo_mem [DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OUT_W-1:0] outstanding;
  logic             rsp_valid;
  logic             full;
  logic             empty;
  logic             load_blocked;
  logic             push;
  logic             pop;
  logic             issue_load;
  logic             rsp_in;
  logic             rsp_out;
  logic             unexp;

  // Handshake decode; all sync/notify outputs are forced low while reset is held.
  always_comb begin
    head           = fifo_mem[rd_ptr];
    full           = (fifo_count == CNT_W'(DEPTH));
    empty          = (fifo_count == '0);
    load_blocked   = !head.wr && (outstanding == OUT_W'(MAX_OUTSTANDING));
    cpu_req_sync   = !rst && !full;
    mem_req_notify = !rst && !empty && !load_blocked;
    mem_rsp_sync   = !rst && (!rsp_valid || cpu_rsp_sync);
    cpu_rsp_notify = rsp_valid;
    mem_req_addr   = head.addr;
    mem_req_data   = head.data;
    mem_req_mask   = head.mask;
    mem_req_wr     = head.wr;
    push           = cpu_req_notify && cpu_req_sync;
    pop            = mem_req_notify && mem_req_sync;
    issue_load     = pop && !head.wr;
    rsp_in         = mem_rsp_notify && mem_rsp_sync;
    rsp_out        = cpu_rsp_notify && cpu_rsp_sync;
    unexp          = rsp_in && (outstanding == '0);
  end

  // Request storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (push) begin
      fifo_mem[wr_ptr] <= '{addr: cpu_req_addr, data: cpu_req_data,
                            mask: cpu_req_mask, wr: cpu_req_wr};
    end
  end

  // Pointers and occupancy; no bypass, so a full FIFO never pushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  // Loads count as outstanding from issue until the CPU takes their data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (issue_load && !rsp_out) begin
      outstanding <= outstanding + OUT_W'(1);
    end else if (rsp_out && !issue_load) begin
      outstanding <= outstanding - OUT_W'(1);
    end
  end

  // Response register and sticky unexpected-response flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid     <= 1'b0;
      cpu_rsp_data  <= '0;
      err_unexp_rsp <= 1'b0;
    end else begin
      if (unexp) begin
        err_unexp_rsp <= 1'b1;
      end
      if (rsp_in && !unexp) begin
        rsp_valid    <= 1'b1;
        cpu_rsp_data <= mem_rsp_data;
      end else if (rsp_out) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_bridge.sv
// Bench for mem_req_bridge: directed vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_mem_req_bridge;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_req_addr;
  logic [31:0] cpu_req_data;
  logic [2:0]  cpu_req_mask;
  logic        cpu_req_wr;
  logic        cpu_req_notify;
  logic        cpu_req_sync;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [2:0]  mem_req_mask;
  logic        mem_req_wr;
  logic        mem_req_notify;
  logic        mem_req_sync;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_notify;
  logic        mem_rsp_sync;
  logic [31:0] cpu_rsp_data;
  logic        cpu_rsp_notify;
  logic        cpu_rsp_sync;
  logic [2:0]  fifo_count;
  logic        err_unexp_rsp;

  mem_req_bridge #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data), .cpu_req_mask(cpu_req_mask),
    .cpu_req_wr(cpu_req_wr), .cpu_req_notify(cpu_req_notify), .cpu_req_sync(cpu_req_sync),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_req_wr(mem_req_wr), .mem_req_notify(mem_req_notify), .mem_req_sync(mem_req_sync),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_notify(mem_rsp_notify), .mem_rsp_sync(mem_rsp_sync),
    .cpu_rsp_data(cpu_rsp_data), .cpu_rsp_notify(cpu_rsp_notify), .cpu_rsp_sync(cpu_rsp_sync),
    .fifo_count(fifo_count), .err_unexp_rsp(err_unexp_rsp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    cpu_req_notify = 1'b0; cpu_req_wr = 1'b0; cpu_req_addr = '0; cpu_req_data = '0;
    cpu_req_mask = '0; mem_req_sync = 1'b0; mem_rsp_notify = 1'b0; mem_rsp_data = '0;
    cpu_rsp_sync = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cpu_offer(input logic wr, input logic [31:0] addr);
    cpu_req_notify = 1'b1; cpu_req_wr = wr; cpu_req_addr = addr;
    cpu_req_data = addr ^ 32'hA5A5_0000; cpu_req_mask = 3'd2;
  endtask

  typedef struct {
    logic cn; logic cwr; logic [31:0] caddr; logic ms; logic rn; logic [31:0] rd; logic cs;
    logic e_creq; logic e_mreq; logic [31:0] e_maddr; logic [2:0] e_cnt;
    logic e_mrsp; logic e_crsp; logic [31:0] e_cdata; logic e_err;
  } vec_t;

  function automatic vec_t mk(input logic cn, input logic cwr, input logic [31:0] caddr,
                              input logic ms, input logic rn, input logic [31:0] rd,
                              input logic cs, input logic e_creq, input logic e_mreq,
                              input logic [31:0] e_maddr, input logic [2:0] e_cnt,
                              input logic e_mrsp, input logic e_crsp,
                              input logic [31:0] e_cdata, input logic e_err);
    vec_t v;
    v.cn = cn; v.cwr = cwr; v.caddr = caddr; v.ms = ms; v.rn = rn; v.rd = rd; v.cs = cs;
    v.e_creq = e_creq; v.e_mreq = e_mreq; v.e_maddr = e_maddr; v.e_cnt = e_cnt;
    v.e_mrsp = e_mrsp; v.e_crsp = e_crsp; v.e_cdata = e_cdata; v.e_err = e_err;
    return v;
  endfunction

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  mask;
    logic        wr;
  } mreq_t;

  vec_t vecs [16];

  initial begin
    rst = 1'b1;
    idle();

    // Columns: cn wr addr ms rn rdata cs | creq mreq maddr cnt mrsp crsp cdata err
    vecs[0]  = mk(0,0,32'h00,0,0,32'h0,       0, 1,0,32'h00,0,1,0,32'h0,       0);
    vecs[1]  = mk(1,0,32'h00,0,0,32'h0,       0, 1,0,32'h00,0,1,0,32'h0,       0);
    vecs[2]  = mk(0,0,32'h00,1,0,32'h0,       0, 1,1,32'h00,1,1,0,32'h0,       0);
    vecs[3]  = mk(0,0,32'h00,0,1,32'h00100073,0, 1,0,32'h00,0,1,0,32'h0,       0);
    vecs[4]  = mk(0,0,32'h00,0,0,32'h0,       0, 1,0,32'h00,0,0,1,32'h00100073,0);
    vecs[5]  = mk(0,0,32'h00,0,0,32'h0,       1, 1,0,32'h00,0,1,1,32'h00100073,0);
    vecs[6]  = mk(0,0,32'h00,0,1,32'hDEAD,    0, 1,0,32'h00,0,1,0,32'h00100073,0);
    vecs[7]  = mk(0,0,32'h00,0,0,32'h0,       0, 1,0,32'h00,0,1,0,32'h00100073,1);
    vecs[8]  = mk(1,1,32'h40,1,0,32'h0,       0, 1,0,32'h00,0,1,0,32'h00100073,1);
    vecs[9]  = mk(1,0,32'h44,0,0,32'h0,       0, 1,1,32'h40,1,1,0,32'h00100073,1);
    vecs[10] = mk(0,0,32'h00,1,0,32'h0,       0, 1,1,32'h40,2,1,0,32'h00100073,1);
    vecs[11] = mk(0,0,32'h00,1,0,32'h0,       0, 1,1,32'h44,1,1,0,32'h00100073,1);
    vecs[12] = mk(0,0,32'h00,0,0,32'h0,       0, 1,0,32'h00,0,1,0,32'h00100073,1);
    vecs[13] = mk(0,0,32'h00,0,1,32'h1234,    1, 1,0,32'h00,0,1,0,32'h00100073,1);
    vecs[14] = mk(0,0,32'h00,0,0,32'h0,       1, 1,0,32'h00,0,1,1,32'h1234,    1);
    vecs[15] = mk(0,0,32'h00,0,0,32'h0,       0, 1,0,32'h00,0,1,0,32'h1234,    1);

    // Directed table: one row per cycle, outputs sampled before the committing edge.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle();
      if (vecs[i].cn) cpu_offer(vecs[i].cwr, vecs[i].caddr);
      mem_req_sync = vecs[i].ms; mem_rsp_notify = vecs[i].rn;
      mem_rsp_data = vecs[i].rd; cpu_rsp_sync = vecs[i].cs;
      #1;
      chk($sformatf("vec%0d_cpu_req_sync", i), 64'(cpu_req_sync), 64'(vecs[i].e_creq));
      chk($sformatf("vec%0d_mem_req_notify", i), 64'(mem_req_notify), 64'(vecs[i].e_mreq));
      if (vecs[i].e_mreq)
        chk($sformatf("vec%0d_mem_req_addr", i), 64'(mem_req_addr), 64'(vecs[i].e_maddr));
      chk($sformatf("vec%0d_fifo_count", i), 64'(fifo_count), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_mem_rsp_sync", i), 64'(mem_rsp_sync), 64'(vecs[i].e_mrsp));
      chk($sformatf("vec%0d_cpu_rsp_notify", i), 64'(cpu_rsp_notify), 64'(vecs[i].e_crsp));
      chk($sformatf("vec%0d_cpu_rsp_data", i), 64'(cpu_rsp_data), 64'(vecs[i].e_cdata));
      chk($sformatf("vec%0d_err_unexp_rsp", i), 64'(err_unexp_rsp), 64'(vecs[i].e_err));
    end

    // Fill with 5 stores while Memory stalls, then push+pop on a full FIFO, then drain.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle();
      cpu_offer(1'b1, 32'h10 + 32'(4 * i));
      #1;
      chk($sformatf("fill%0d_cpu_req_sync", i), 64'(cpu_req_sync), 64'(i < 4));
    end
    chk("fill_count", 64'(fifo_count), 64'd4);
    @(negedge clk);
    mem_req_sync = 1'b1;
    #1;
    chk("full_pushpop_sync", 64'(cpu_req_sync), 64'd0);
    chk("full_pushpop_notify", 64'(mem_req_notify), 64'd1);
    chk("full_pushpop_addr", 64'(mem_req_addr), 64'h10);
    @(negedge clk);
    mem_req_sync = 1'b0;
    #1;
    chk("after_pop_count", 64'(fifo_count), 64'd3);
    chk("after_pop_sync", 64'(cpu_req_sync), 64'd1);
    @(negedge clk);
    cpu_req_notify = 1'b0;
    mem_req_sync = 1'b1;
    #1;
    chk("refill_count", 64'(fifo_count), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      chk($sformatf("drain%0d_notify", k), 64'(mem_req_notify), 64'd1);
      chk($sformatf("drain%0d_addr", k), 64'(mem_req_addr), 64'h14 + 64'(4 * k));
      chk($sformatf("drain%0d_wr", k), 64'(mem_req_wr), 64'd1);
    end
    @(negedge clk);
    mem_req_sync = 1'b0;
    #1;
    chk("drain_empty_count", 64'(fifo_count), 64'd0);

    // Outstanding-load limit: three loads queued, only two may issue.
    begin
      int issued;
      issued = 0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        cpu_offer(1'b0, 32'h100 + 32'(4 * i));
      end
      @(negedge clk);
      cpu_req_notify = 1'b0;
      mem_req_sync = 1'b1;
      for (int c = 0; c < 6; c++) begin
        if (c > 0) @(negedge clk);
        #1;
        if (mem_req_notify) issued++;
      end
      chk("limit_issued", 64'(issued), 64'd2);
      chk("limit_notify", 64'(mem_req_notify), 64'd0);
      chk("limit_count", 64'(fifo_count), 64'd1);
      @(negedge clk);
      mem_rsp_notify = 1'b1; mem_rsp_data = 32'h55;
      #1;
      chk("limit_mrsp_sync", 64'(mem_rsp_sync), 64'd1);
      @(negedge clk);
      mem_rsp_notify = 1'b0; cpu_rsp_sync = 1'b1;
      #1;
      chk("limit_crsp_notify", 64'(cpu_rsp_notify), 64'd1);
      chk("limit_still_held", 64'(mem_req_notify), 64'd0);
      @(negedge clk);
      cpu_rsp_sync = 1'b0;
      #1;
      chk("limit_release_notify", 64'(mem_req_notify), 64'd1);
      chk("limit_release_addr", 64'(mem_req_addr), 64'h108);
      @(negedge clk);
      mem_req_sync = 1'b0;
      #1;
      chk("limit_third_issued", 64'(fifo_count), 64'd0);
    end

    // Asynchronous reset with 3 queued entries and a held response.
    do_reset();
    @(negedge clk);
    cpu_offer(1'b0, 32'h200);
    @(negedge clk);
    cpu_req_notify = 1'b0; mem_req_sync = 1'b1;
    @(negedge clk);
    mem_req_sync = 1'b0; mem_rsp_notify = 1'b1; mem_rsp_data = 32'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rsp_notify = 1'b0;
      cpu_offer(1'b1, 32'h300 + 32'(4 * i));
    end
    @(negedge clk);
    cpu_req_notify = 1'b0;
    #1;
    chk("pre_rst_count", 64'(fifo_count), 64'd3);
    chk("pre_rst_crsp", 64'(cpu_rsp_notify), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 64'(fifo_count), 64'd0);
    chk("arst_cpu_req_sync", 64'(cpu_req_sync), 64'd0);
    chk("arst_mem_req_notify", 64'(mem_req_notify), 64'd0);
    chk("arst_mem_rsp_sync", 64'(mem_rsp_sync), 64'd0);
    chk("arst_cpu_rsp_notify", 64'(cpu_rsp_notify), 64'd0);
    chk("arst_cpu_rsp_data", 64'(cpu_rsp_data), 64'd0);
    chk("arst_err", 64'(err_unexp_rsp), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cpu_offer(1'b0, 32'h400);
    #1;
    chk("post_rst_sync", 64'(cpu_req_sync), 64'd1);
    @(negedge clk);
    cpu_req_notify = 1'b0;
    #1;
    chk("post_rst_notify", 64'(mem_req_notify), 64'd1);
    chk("post_rst_addr", 64'(mem_req_addr), 64'h400);

    // Randomized traffic against a queue-based model; the Memory emulator only
    // returns data for loads it has actually accepted.
    begin
      mreq_t q[$];
      mreq_t cur;
      mreq_t h;
      int    outs;
      int    mem_pend;
      logic  m_rv;
      logic  m_err;
      logic [31:0] m_rdata;
      logic [31:0] rsp_d;
      logic  cpu_off;
      logic  rsp_off;
      logic  e_creq, e_mreq, e_mrsp, push, pop, rin, rout, unexp, lpop;

      do_reset();
      outs = 0; mem_pend = 0; m_rv = 1'b0; m_err = 1'b0; m_rdata = '0;
      rsp_d = '0; cpu_off = 1'b0; rsp_off = 1'b0; cur = '0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if (!cpu_off) begin
          cpu_off  = ($urandom_range(0, 3) != 0);
          cur.addr = $urandom & 32'hFFFF_FFFC;
          cur.data = $urandom;
          cur.mask = 3'($urandom_range(0, 7));
          cur.wr   = 1'($urandom_range(0, 1));
        end
        cpu_req_notify = cpu_off; cpu_req_addr = cur.addr; cpu_req_data = cur.data;
        cpu_req_mask = cur.mask; cpu_req_wr = cur.wr;
        mem_req_sync = 1'($urandom_range(0, 1));
        cpu_rsp_sync = ($urandom_range(0, 2) != 0);
        if (!rsp_off && mem_pend > 0 && $urandom_range(0, 1) == 1) begin
          rsp_off = 1'b1;
          rsp_d   = $urandom;
        end
        mem_rsp_notify = rsp_off; mem_rsp_data = rsp_d;
        #1;
        e_creq = (q.size() < DEPTH);
        e_mreq = 1'b0;
        if (q.size() > 0) e_mreq = !(!q[0].wr && outs == MAXO);
        e_mrsp = !m_rv || cpu_rsp_sync;
        chk("rnd_cpu_req_sync", 64'(cpu_req_sync), 64'(e_creq));
        chk("rnd_mem_req_notify", 64'(mem_req_notify), 64'(e_mreq));
        if (e_mreq) begin
          chk("rnd_mem_req_addr", 64'(mem_req_addr), 64'(q[0].addr));
          chk("rnd_mem_req_data", 64'(mem_req_data), 64'(q[0].data));
          chk("rnd_mem_req_mask", 64'(mem_req_mask), 64'(q[0].mask));
          chk("rnd_mem_req_wr", 64'(mem_req_wr), 64'(q[0].wr));
        end
        chk("rnd_fifo_count", 64'(fifo_count), 64'(q.size()));
        chk("rnd_mem_rsp_sync", 64'(mem_rsp_sync), 64'(e_mrsp));
        chk("rnd_cpu_rsp_notify", 64'(cpu_rsp_notify), 64'(m_rv));
        chk("rnd_cpu_rsp_data", 64'(cpu_rsp_data), 64'(m_rdata));
        chk("rnd_err", 64'(err_unexp_rsp), 64'(m_err));

        push  = cpu_off && e_creq;
        pop   = e_mreq && mem_req_sync;
        rin   = rsp_off && e_mrsp;
        rout  = m_rv && cpu_rsp_sync;
        unexp = rin && (outs == 0);
        lpop  = 1'b0;
        if (pop) begin
          h = q.pop_front();
          lpop = !h.wr;
          if (lpop) mem_pend++;
        end
        if (push) begin
          q.push_back(cur);
          cpu_off = 1'b0;
        end
        if (rin) begin
          rsp_off = 1'b0;
          mem_pend--;
        end
        if (unexp) m_err = 1'b1;
        if (rin && !unexp) begin
          m_rv = 1'b1;
          m_rdata = rsp_d;
        end else if (rout) begin
          m_rv = 1'b0;
        end
        outs = outs + int'(lpop) - int'(rout);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
